// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: size codes, FSM states, request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam int MAX_WAIT_CYCLES = 15;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Illegal size code or an access that straddles its natural alignment.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_X) ||
               ((size == SZ_H) && lo[0]) ||
               ((size == SZ_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/half/word from a memory word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
module dmem_load_align (
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] data
);
    import dmem_pkg::*;

    logic [31:0] sh;

    always_comb begin
        sh   = word >> {addr_lo, 3'b000};
        data = '0;
        case (size)
            SZ_B:    data = load_unsigned ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    data = load_unsigned ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            SZ_W:    data = sh;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with load/store request port; wiped to zero after every reset.
// Latency: response WAIT_CYCLES+1 cycles after the accept edge, one request in flight.
// Backpressure: req_ready only in IDLE; responses cannot be stalled.
module data_mem_lsu #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        clr_busy
);
    import dmem_pkg::*;

    localparam int IDX_W    = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int WORDS    = 2 ** (ADDR_W - 2);
    localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [ADDR_W-1:0] baddr_t;

    localparam idx_t       CLR_LAST  = idx_t'(WORDS - 1);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_EFF > 0) ? WAIT_EFF - 1 : 0);

    logic [7:0]  mem [2**ADDR_W];

    state_t      state;
    idx_t        clr_idx;
    logic [3:0]  cnt;
    req_t        req_q;
    req_t        req_live;
    req_t        acc;

    logic        acc_fire;
    logic        acc_err;
    idx_t        acc_idx;
    logic [31:0] rd_word;
    logic [31:0] ld_data;

    logic        wr_en;
    idx_t        wr_idx;
    logic [3:0]  wr_be;
    logic [31:0] wr_dat;

    always_comb begin
        req_live.we    = req_we;
        req_live.size  = req_size;
        req_live.uns   = req_unsigned;
        req_live.addr  = req_addr;
        req_live.wdata = req_wdata;
    end

    // With zero wait states the access happens on the accept edge itself, so
    // the live request fields stand in for the not-yet-latched copy.
    always_comb begin
        acc      = (state == ST_IDLE) ? req_live : req_q;
        acc_fire = ((state == ST_WAIT) && (cnt == 4'd0)) ||
                   ((WAIT_EFF == 0) && (state == ST_IDLE) && req_valid);
        acc_err  = size_misaligned(acc.size, acc.addr[1:0]) ||
                   ((acc.addr >> ADDR_W) != 32'd0);
        acc_idx  = idx_t'(acc.addr >> 2);
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            rd_word[8*k +: 8] = mem[baddr_t'({acc_idx, 2'(k)})];
        end
    end

    dmem_load_align u_align (
        .word          (rd_word),
        .addr_lo       (acc.addr[1:0]),
        .size          (acc.size),
        .load_unsigned (acc.uns),
        .data          (ld_data)
    );

    // One write port shared by the post-reset wipe and by stores.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = acc_idx;
        wr_be  = 4'h0;
        wr_dat = acc.wdata << {acc.addr[1:0], 3'b000};
        if (state == ST_CLEAR) begin
            wr_en  = 1'b1;
            wr_idx = clr_idx;
            wr_be  = 4'hF;
            wr_dat = '0;
        end else if (acc_fire && acc.we && !acc_err) begin
            wr_en = 1'b1;
            case (acc.size)
                SZ_B:    wr_be = 4'b0001 << acc.addr[1:0];
                SZ_H:    wr_be = 4'b0011 << acc.addr[1:0];
                default: wr_be = 4'b1111;
            endcase
        end
    end

    // Reset on the access edge must abort the store, hence the reset gate.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem[baddr_t'({wr_idx, 2'(k)})] <= wr_dat[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clr_idx   <= '0;
            cnt       <= 4'd0;
            req_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b0;
            clr_busy  <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_idx == CLR_LAST) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        clr_busy  <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + idx_t'(1);
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q     <= req_live;
                        req_ready <= 1'b0;
                        if (WAIT_EFF == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
            if (acc_fire) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc.we) ? 32'h0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed scenarios plus random traffic against a byte-array model.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        v1 = 1'b0, v0 = 1'b0, v3 = 1'b0;
    logic        rdy1, rdy0, rdy3;
    logic        rv1, rv0, rv3;
    logic        err1, err0, err3;
    logic        busy1, busy0, busy3;
    logic [31:0] rd1, rd0, rd3;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [256];

    data_mem_lsu #(.ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1), .clr_busy(busy1));

    data_mem_lsu #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0), .clr_busy(busy0));

    data_mem_lsu #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3), .clr_busy(busy3));

    // ---------------- reference model ----------------
    function automatic bit exp_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'b00) || (addr > 32'd255);
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        int     n = 1 << size;
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[int'(addr) + i]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 1 << size;
        for (int i = 0; i < n; i++) mdl[int'(addr) + i] = 8'(wdata >> (8 * i));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    endtask

    // Drives one request on the WAIT_CYCLES=1 instance; lat = -1 on timeout.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        v1 = 1'b1;
        n = 0;
        while (!rdy1 && n < 200) begin @(negedge clk); n++; end
        lat = -1; rdata = 32'hDEAD_DEAD; err = 1'b0;
        if (rdy1) begin
            @(posedge clk);
            @(negedge clk);
            v1 = 1'b0;
            lat = 1;
            while (!rv1 && lat < 40) begin @(negedge clk); lat++; end
            if (rv1) begin rdata = rd1; err = err1; end else lat = -1;
        end else begin
            v1 = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int cnt;
        @(negedge clk);
        v1 = 0; v0 = 0; v3 = 0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy1); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy1); end
        checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rv1); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rd1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err1); end
        cnt = 0;
        while (busy1 && cnt < 500) begin cnt++; @(negedge clk); end
        checks++; if (cnt != 64) begin errors++; $display("FAIL clear_cycles: got %0d expected 64", cnt); end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL ready_after_clear: got %b expected 1", rdy1); end
        model_clear();
    endtask

    task automatic test_clear_loads();
        logic [31:0] rd; logic er; int lat;
        for (int a = 0; a < 256; a += 4) begin
            do_req(1'b0, 2'd2, 1'b0, 32'(a), 32'h0, rd, er, lat);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clear_load[%h]: got %h expected 0", a, rd); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL clear_err[%h]: got %b expected 0", a, er); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat;
        logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
        logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad [4] = '{32'h10, 32'h11, 32'h12, 32'h10};
        logic [31:0] ex [4] = '{32'hFFFFFFBB, 32'h000000AA, 32'hFFFF8899, 32'h8899AABB};
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, rd, er, lat);
        model_store(2'd2, 32'h10, 32'h8899AABB);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL basic_store: got %h/%b expected 0/0", rd, er); end
        checks++; if (lat != 2) begin errors++; $display("FAIL basic_store_lat: got %0d expected 2", lat); end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, rd, er, lat);
            checks++; if (rd !== ex[i]) begin errors++; $display("FAIL basic_load[%0d]: got %h expected %h", i, rd, ex[i]); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_err[%0d]: got %b expected 0", i, er); end
            checks++; if (lat != 2) begin errors++; $display("FAIL basic_lat[%0d]: got %0d expected 2", i, lat); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        logic        we [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] ad [5] = '{32'h21, 32'h22, 32'h20, 32'h100, 32'h80000020};
        logic [31:0] wd [5] = '{32'h1234, 32'h55667788, 32'h0, 32'h0, 32'hAB};
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, rd, er, lat);
        model_store(2'd2, 32'h20, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            do_req(we[i], sz[i], 1'b0, ad[i], wd[i], rd, er, lat);
            checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_flag[%0d]: got %b expected 1", i, er); end
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rdata[%0d]: got %h expected 0", i, rd); end
            checks++; if (lat != 2) begin errors++; $display("FAIL err_lat[%0d]: got %0d expected 2", i, lat); end
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
        checks++; if (rd !== exp_load(2'd2, 1'b0, 32'h20)) begin
            errors++; $display("FAIL err_mem_unchanged: got %h expected %h", rd, exp_load(2'd2, 1'b0, 32'h20));
        end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat);
        do_req(1'b1, 2'd0, 1'b0, 32'h33, 32'h7F, rd, er, lat);
        model_store(2'd2, 32'h30, 32'h0);
        model_store(2'd0, 32'h33, 32'h7F);
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h7F000000) begin errors++; $display("FAIL byte_merge: got %h expected 7f000000", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, exp_rd; logic er, we, uns, exp_e; logic [1:0] size; int lat, r;
        for (int i = 0; i < 300; i++) begin
            r     = $urandom_range(0, 9);
            addr  = (r == 0) ? $urandom : 32'($urandom_range(0, 255));
            size  = 2'($urandom_range(0, 3));
            if (r < 7 && size == 2'd1) addr[0] = 1'b0;
            if (r < 7 && size == 2'd2) addr[1:0] = 2'b00;
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            exp_e  = exp_err(size, addr);
            exp_rd = (exp_e || we) ? 32'h0 : exp_load(size, uns, addr);
            do_req(we, size, uns, addr, wdata, rd, er, lat);
            if (!exp_e && we) model_store(size, addr, wdata);
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, rd, exp_rd); end
            checks++; if (er !== exp_e) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, er, exp_e); end
            checks++; if (lat != 2) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected 2", i, lat); end
        end
    endtask

    task automatic test_reset_in_clear();
        int cnt;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (busy1 && cnt < 500) begin cnt++; @(negedge clk); end
        checks++; if (cnt != 64) begin errors++; $display("FAIL restart_clear_cycles: got %0d expected 64", cnt); end
        model_clear();
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat, n, seen;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
        v1 = 1'b1;
        n = 0;
        while (!rdy1 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0; reset = 1'b1;
        seen = rv1 ? 1 : 0;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while ((busy1 || n < 3) && n < 500) begin
            if (rv1) seen++;
            @(negedge clk); n++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_rsp: got %0d pulses expected 0", seen); end
        model_clear();
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_mem: got %h expected 0", rd); end
    endtask

    task automatic test_back_to_back(input int w);
        int acc_t[$], rsp_t[$];
        int m;
        logic r, rv;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        if (w == 0) v0 = 1'b1; else v3 = 1'b1;
        for (int t = 0; t < 30; t++) begin
            r  = (w == 0) ? rdy0 : rdy3;
            rv = (w == 0) ? rv0 : rv3;
            if (rv) rsp_t.push_back(t);
            if (r) acc_t.push_back(t);
            @(negedge clk);
        end
        v0 = 1'b0; v3 = 1'b0;
        checks++; if (acc_t.size() < 4) begin errors++; $display("FAIL b2b_w%0d_accepts: got %0d expected >=4", w, acc_t.size()); end
        for (int i = 1; i < acc_t.size(); i++) begin
            checks++; if (acc_t[i] - acc_t[i-1] != w + 2) begin
                errors++; $display("FAIL b2b_w%0d_gap[%0d]: got %0d expected %0d", w, i, acc_t[i] - acc_t[i-1], w + 2);
            end
        end
        m = (rsp_t.size() < acc_t.size()) ? rsp_t.size() : acc_t.size();
        checks++; if (m < 3) begin errors++; $display("FAIL b2b_w%0d_rsps: got %0d expected >=3", w, m); end
        for (int i = 0; i < m; i++) begin
            checks++; if (rsp_t[i] - acc_t[i] != w + 1) begin
                errors++; $display("FAIL b2b_w%0d_lat[%0d]: got %0d expected %0d", w, i, rsp_t[i] - acc_t[i], w + 1);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clear_loads();
        test_basic();
        test_errors();
        test_byte_merge();
        test_random();
        test_reset();
        test_clear_loads();
        test_reset_in_clear();
        test_reset_abort();
        test_back_to_back(0);
        test_back_to_back(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
